// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered
// output stage and a pending-write scoreboard for read-after-write hazard detection.
module regfile_write_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ENC_W    = 3,
    parameter int NUM_REGS = 8,
    parameter int NREQ     = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hold,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*ENC_W-1:0]    req_enc,
    input  logic [NREQ*2-1:0]        req_mask,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    input  logic                     rsv_valid,
    input  logic [ENC_W-1:0]         rsv_enc,
    input  logic [ENC_W-1:0]         rd_enc_0,
    input  logic [ENC_W-1:0]         rd_enc_1,
    output logic                     hazard,
    output logic [NUM_REGS-1:0]      pending,
    output logic [1:0]               we,
    output logic [ENC_W-1:0]         r_write_enc,
    output logic [DATA_W-1:0]        wdata,
    output logic [1:0]               grant_id
);

    logic [1:0]          r_ptr;
    logic [1:0]          r_we;
    logic [ENC_W-1:0]    r_enc;
    logic [DATA_W-1:0]   r_wdata;
    logic [1:0]          r_gid;
    logic [NUM_REGS-1:0] r_pending;

    logic                w_xfer;
    logic [1:0]          w_gidx;
    logic [NREQ-1:0]     w_grant;
    logic [ENC_W-1:0]    w_sel_enc;
    logic [1:0]          w_sel_mask;
    logic [DATA_W-1:0]   w_sel_data;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_set;
    logic [NUM_REGS-1:0] w_pend_nxt;

    // First valid requester in the priority order p0, p1, p2.
    function automatic logic [1:0] first_of(
        input logic [NREQ-1:0] v,
        input logic [1:0]      p0,
        input logic [1:0]      p1,
        input logic [1:0]      p2
    );
        logic [1:0] sel;
        if (v[p0]) begin
            sel = p0;
        end else if (v[p1]) begin
            sel = p1;
        end else begin
            sel = p2;
        end
        return sel;
    endfunction

    assign w_xfer = ~hold & (|req_valid);

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        w_gidx = 2'd0;
        case (r_ptr)
            2'd0:    w_gidx = first_of(req_valid, 2'd1, 2'd2, 2'd0);
            2'd1:    w_gidx = first_of(req_valid, 2'd2, 2'd0, 2'd1);
            default: w_gidx = first_of(req_valid, 2'd0, 2'd1, 2'd2);
        endcase
    end

    assign w_grant    = w_xfer ? (NREQ'(1) << w_gidx) : '0;
    assign req_ready  = w_grant;

    assign w_sel_enc  = req_enc[w_gidx*ENC_W +: ENC_W];
    assign w_sel_mask = req_mask[w_gidx*2 +: 2];
    assign w_sel_data = req_data[w_gidx*DATA_W +: DATA_W];

    // A reservation in the same cycle as a retiring write to that register wins.
    assign w_clr      = (w_xfer && (w_sel_mask != 2'b00)) ? (NUM_REGS'(1) << w_sel_enc) : '0;
    assign w_set      = rsv_valid ? (NUM_REGS'(1) << rsv_enc) : '0;
    assign w_pend_nxt = (r_pending & ~w_clr) | w_set;

    // Output stage, round-robin pointer and scoreboard state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr     <= 2'd2;
            r_we      <= 2'b00;
            r_enc     <= '0;
            r_wdata   <= '0;
            r_gid     <= 2'd0;
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_nxt;
            if (w_xfer) begin
                r_ptr   <= w_gidx;
                r_we    <= w_sel_mask;
                r_enc   <= w_sel_enc;
                r_wdata <= w_sel_data;
                r_gid   <= w_gidx;
            end else begin
                r_we    <= 2'b00;
            end
        end
    end

    assign pending     = r_pending;
    assign hazard      = r_pending[rd_enc_0] | r_pending[rd_enc_1];
    assign we          = r_we;
    assign r_write_enc = r_enc;
    assign wdata       = r_wdata;
    assign grant_id    = r_gid;

endmodule
